pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 32, SHALL set the width of the PC and of all address ports.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_ready  in  1  instruction memory holds valid data for the current PC.
- Branch  in  1  current instruction is a conditional branch.
- BranchTaken  in  1  branch comparator result.
- Jump  in  1  current instruction is JAL/JALR.
- md_op  in  1  current instruction is a multi-cycle MUL/DIV.
- md_done  in  1  MUL/DIV unit result valid (1-cycle pulse).
- BranchTarget  in  PC_WIDTH  branch destination.
- JumpTarget  in  PC_WIDTH  jump destination.
- PC  out  PC_WIDTH  registered program counter.
- PC_Plus_4  out  PC_WIDTH  PC + 4, combinational.
- PCSrc  out  2  next-PC select: 00 PC+4, 01 branch, 10 jump.
- stall  out  1  register-file and data-memory writes SHALL be suppressed while high.
- md_req  out  1  1-cycle start pulse to the MUL/DIV unit.
- retire  out  1  1-cycle pulse when an instruction commits.
- trap  out  1  sticky misaligned-target fault flag.
- retire_cnt  out  32  count of retired instructions.

Function
REQ-004 PC_Plus_4 SHALL equal PC + 4 modulo 2^PC_WIDTH; 32'hFFFF_FFFC wraps to 0.
REQ-005 PCSrc SHALL be combinational: 10 if Jump; else 01 if Branch && BranchTaken; else 00. Jump has priority over Branch.
REQ-006 The selected next-PC value SHALL be PC_Plus_4, BranchTarget or JumpTarget according to PCSrc.
REQ-007 The block SHALL have four FSM states: BOOT, RUN, WAIT_MD and HALT.
REQ-008 BOOT SHALL last exactly one cycle with stall=1, then go to RUN; PC SHALL hold RESET_VECTOR.
REQ-009 RUN with imem_ready=0: PC SHALL hold, stall=1, retire=0, and md_op SHALL be ignored.
REQ-010 RUN with imem_ready=1 and md_op=0: the selected target SHALL be checked for alignment.
- Aligned: PC SHALL load the next-PC value at the next edge, with retire=1 and stall=0.
- Misaligned (selected target bits [1:0] != 0 while PCSrc != 00): go to HALT, PC holds, retire=0, stall=1.
REQ-011 RUN with imem_ready=1 and md_op=1: md_req=1 for exactly that cycle, stall=1, PC holds, next state WAIT_MD.
REQ-012 WAIT_MD: stall=1 and PC holds until md_done=1.
- In the md_done cycle: stall=0 and retire=1; PC SHALL load PC_Plus_4 at that edge; next state RUN.
- md_req SHALL NOT re-assert while in WAIT_MD.
REQ-013 md_done SHALL be ignored in BOOT, RUN and HALT.
REQ-014 HALT SHALL be absorbing until rst: trap=1, stall=1, PC frozen, md_req=0, retire=0.
REQ-015 retire_cnt SHALL increment by 1 on every cycle with retire=1 and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-016 Jump and Branch SHALL be ignored whenever md_op=1; a MUL/DIV instruction always advances to PC+4.

Reset
REQ-017 When rst=1 at an edge, the outputs SHALL take these values on the following cycle, from any state, including mid-WAIT_MD:
- PC=RESET_VECTOR, state=BOOT.
- trap=0, retire_cnt=0.
- md_req=0, retire=0, stall=1.
REQ-018 When rst=1 at an edge, a pending MUL/DIV operation SHALL be abandoned, and a late md_done SHALL be ignored.

Verification
REQ-019 Reset release, imem_ready=1, no control inputs -> PC sequence 0,0,4,8,C; retire_cnt=3 after 5 cycles.
REQ-020 PC=0x10, Branch=1, BranchTaken=1, BranchTarget=0x40, Jump=1, JumpTarget=0x80 -> PCSrc=10, next PC=0x80.
REQ-021 PC=0x20, md_op=1, md_done asserted 5 cycles later -> md_req exactly 1 cycle, PC=0x20 for 6 cycles, then PC=0x24, with one retire pulse.
REQ-022 PC=0x30, Jump=1, JumpTarget=0x42 -> trap=1, PC stays 0x30, and retire_cnt stays frozen for 10 cycles.
REQ-023 rst asserted during WAIT_MD, md_done 2 cycles later -> PC=0, trap=0, no retire pulse.
REQ-024 imem_ready=0 for 3 cycles at PC=0x8 -> PC held at 0x8 with stall=1 throughout; no retire.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, boot/run/multi-cycle-wait/halt
// control, misaligned-target trap and retired-instruction counting.
module pc_sequencer #(
    parameter int                     PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_ready,
    input  logic                Branch,
    input  logic                BranchTaken,
    input  logic                Jump,
    input  logic                md_op,
    input  logic                md_done,
    input  logic [PC_WIDTH-1:0] BranchTarget,
    input  logic [PC_WIDTH-1:0] JumpTarget,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] PC_Plus_4,
    output logic [1:0]          PCSrc,
    output logic                stall,
    output logic                md_req,
    output logic                retire,
    output logic                trap,
    output logic [31:0]         retire_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, WAIT_MD, HALT} state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] next_pc;
    logic                misaligned;

    assign PC_Plus_4 = PC + PC_WIDTH'(4);

    always_comb begin
        PCSrc = 2'b00;
        if (Jump)
            PCSrc = 2'b10;
        else if (Branch && BranchTaken)
            PCSrc = 2'b01;
    end

    always_comb begin
        next_pc = PC_Plus_4;
        case (PCSrc)
            2'b01:   next_pc = BranchTarget;
            2'b10:   next_pc = JumpTarget;
            default: next_pc = PC_Plus_4;
        endcase
    end

    // Sequential PC+4 is always word-aligned, so only redirects can fault.
    assign misaligned = (PCSrc != 2'b00) && (next_pc[1:0] != 2'b00);

    // Handshake outputs depend on the current cycle's inputs (retire and
    // md_req must coincide with the cycle that commits or launches).
    always_comb begin
        stall  = 1'b1;
        retire = 1'b0;
        md_req = 1'b0;
        case (state)
            RUN: begin
                if (imem_ready) begin
                    if (md_op) begin
                        md_req = 1'b1;
                    end else if (!misaligned) begin
                        stall  = 1'b0;
                        retire = 1'b1;
                    end
                end
            end
            WAIT_MD: begin
                if (md_done) begin
                    stall  = 1'b0;
                    retire = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            PC         <= RESET_VECTOR;
            trap       <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (retire)
                retire_cnt <= retire_cnt + 32'd1;
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (imem_ready) begin
                        if (md_op) begin
                            state <= WAIT_MD;
                        end else if (misaligned) begin
                            state <= HALT;
                            trap  <= 1'b1;
                        end else begin
                            PC <= next_pc;
                        end
                    end
                end
                WAIT_MD: begin
                    // MUL/DIV never redirects: it always falls through.
                    if (md_done) begin
                        PC    <= PC_Plus_4;
                        state <= RUN;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each driven cycle queues its expected
// outputs, and a negedge monitor pops and compares them.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready, Branch, BranchTaken, Jump, md_op, md_done;
    logic [31:0] BranchTarget, JumpTarget;
    logic [31:0] PC, PC_Plus_4;
    logic [1:0]  PCSrc;
    logic        stall, md_req, retire, trap;
    logic [31:0] retire_cnt;

    pc_sequencer #(.PC_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_ready(imem_ready), .Branch(Branch),
        .BranchTaken(BranchTaken), .Jump(Jump), .md_op(md_op), .md_done(md_done),
        .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .PC(PC),
        .PC_Plus_4(PC_Plus_4), .PCSrc(PCSrc), .stall(stall), .md_req(md_req),
        .retire(retire), .trap(trap), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // control bundle: {imem_ready, Branch, BranchTaken, Jump, md_op, md_done}
    localparam logic [5:0] IR = 6'b100000, BR = 6'b010000, BT = 6'b001000,
                           JP = 6'b000100, MO = 6'b000010, MD = 6'b000001;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [1:0]  pcsrc;
        logic        stall, retire, md_req, trap;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic rst_cycle();
        @(posedge clk); #1;
        rst = 1'b1;
        {imem_ready, Branch, BranchTaken, Jump, md_op, md_done} = '0;
    endtask

    task automatic step(input string tag, input logic [5:0] ctl,
                        input logic [31:0] bta, input logic [31:0] jta,
                        input logic [31:0] e_pc, input logic e_stall,
                        input logic e_ret, input logic e_mdreq,
                        input logic e_trap, input logic [31:0] e_cnt);
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b0;
        {imem_ready, Branch, BranchTaken, Jump, md_op, md_done} = ctl;
        BranchTarget = bta;
        JumpTarget   = jta;
        e.tag    = tag;
        e.pc     = e_pc;
        e.pcsrc  = ctl[2] ? 2'b10 : (ctl[4] && ctl[3]) ? 2'b01 : 2'b00;
        e.stall  = e_stall;
        e.retire = e_ret;
        e.md_req = e_mdreq;
        e.trap   = e_trap;
        e.cnt    = e_cnt;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".pc"},     PC,                 e.pc);
            chk({e.tag, ".pc4"},    PC_Plus_4,          e.pc + 32'd4);
            chk({e.tag, ".pcsrc"},  32'(PCSrc),         32'(e.pcsrc));
            chk({e.tag, ".stall"},  32'(stall),         32'(e.stall));
            chk({e.tag, ".retire"}, 32'(retire),        32'(e.retire));
            chk({e.tag, ".md_req"}, 32'(md_req),        32'(e.md_req));
            chk({e.tag, ".trap"},   32'(trap),          32'(e.trap));
            chk({e.tag, ".cnt"},    retire_cnt,         e.cnt);
        end
    end

    initial begin
        rst = 1'b1;
        {imem_ready, Branch, BranchTaken, Jump, md_op, md_done} = '0;
        BranchTarget = '0;
        JumpTarget   = '0;
        repeat (2) @(posedge clk);

        // sequential fetch out of reset: 0,0,4,8,C
        //    tag       ctl         bta       jta       pc        st ret mr tr cnt
        step("boot",    IR,         0,        0,        32'h0,    1, 0, 0, 0, 0);
        step("seq0",    IR,         0,        0,        32'h0,    0, 1, 0, 0, 0);
        step("seq4",    IR,         0,        0,        32'h4,    0, 1, 0, 0, 1);
        step("seq8",    IR,         0,        0,        32'h8,    0, 1, 0, 0, 2);
        step("seqC",    IR,         0,        0,        32'hC,    0, 1, 0, 0, 3);
        // jump beats taken branch
        step("prio",    IR|BR|BT|JP, 32'h40,  32'h80,   32'h10,   0, 1, 0, 0, 4);
        step("jmp8",    IR|JP,      0,        32'h8,    32'h80,   0, 1, 0, 0, 5);
        // instruction memory not ready for 3 cycles
        step("nrdy0",   6'b0,       0,        0,        32'h8,    1, 0, 0, 0, 6);
        step("nrdy1",   MO,         0,        0,        32'h8,    1, 0, 0, 0, 6);
        step("nrdy2",   6'b0,       0,        0,        32'h8,    1, 0, 0, 0, 6);
        step("br20",    IR|BR|BT,   32'h20,   0,        32'h8,    0, 1, 0, 0, 6);
        // MUL/DIV at 0x20 with a misaligned jump that must be ignored
        step("mdreq",   IR|MO|JP,   0,        32'h3,    32'h20,   1, 0, 1, 0, 7);
        for (int i = 0; i < 4; i++)
            step("mdwait", IR|MO,   0,        0,        32'h20,   1, 0, 0, 0, 7);
        step("mddone",  MD,         0,        0,        32'h20,   0, 1, 0, 0, 7);
        step("md24",    IR|MD,      0,        0,        32'h24,   0, 1, 0, 0, 8);
        step("ntkn",    IR|BR,      32'h1,    0,        32'h28,   0, 1, 0, 0, 9);
        step("seq2C",   IR,         0,        0,        32'h2C,   0, 1, 0, 0, 10);
        // misaligned jump target traps and freezes
        step("misal",   IR|JP,      0,        32'h42,   32'h30,   1, 0, 0, 0, 11);
        for (int i = 0; i < 10; i++)
            step("halt", (i % 2 == 0) ? (IR|MO) : (IR|MD), 0, 0, 32'h30, 1, 0, 0, 1, 11);

        // reset clears trap and counter; PC wrap at top of address space
        rst_cycle();
        step("rboot",   IR,         0,        0,        32'h0,    1, 0, 0, 0, 0);
        step("jtop",    IR|JP,      0,        32'hFFFF_FFFC, 32'h0, 0, 1, 0, 0, 0);
        step("top",     IR,         0,        0,        32'hFFFF_FFFC, 0, 1, 0, 0, 1);
        step("wrap",    IR,         0,        0,        32'h0,    0, 1, 0, 0, 2);

        // reset during WAIT_MD, late md_done ignored
        step("md2req",  IR|MO,      0,        0,        32'h4,    1, 0, 1, 0, 3);
        step("md2wait", 6'b0,       0,        0,        32'h4,    1, 0, 0, 0, 3);
        rst_cycle();
        step("mrboot",  6'b0,       0,        0,        32'h0,    1, 0, 0, 0, 0);
        step("late",    MD,         0,        0,        32'h0,    1, 0, 0, 0, 0);
        step("after",   IR,         0,        0,        32'h0,    0, 1, 0, 0, 0);
        step("after4",  6'b0,       0,        0,        32'h4,    1, 0, 0, 0, 1);

        @(posedge clk);
        @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
